// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: issues one data-memory transaction at a time, formats
// load data, and produces a single-cycle writeback pulse (with exception/timeout flags).
module load_store_unit #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              valid_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  load_store_unit_if.master dmem,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              stall_out,
  output logic              mem_exc,
  output logic              mem_err
);

  localparam int CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state_q;
  logic               dmem_req_q;
  logic               dmem_we_q;
  logic [31:0]        dmem_addr_q;
  logic [3:0]         dmem_be_q;
  logic [31:0]        dmem_wdata_q;
  logic               wb_valid_q;
  logic [31:0]        wb_data_q;
  logic [4:0]         wb_rd_q;
  logic               wb_reg_write_q;
  logic               mem_exc_q;
  logic               mem_err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         funct3_q;
  logic [1:0]         addr_lo_q;
  logic [4:0]         rd_q;
  logic               reg_write_q;
  logic               is_load_q;

  logic               is_mem;
  logic               accept;
  logic               legal_f3;
  logic               misaligned;
  logic               timeout_hit;
  logic [3:0]         be_d;
  logic [31:0]        wdata_d;
  logic [31:0]        load_data_d;
  logic [7:0]         rdata_bytes [4];
  logic [15:0]        rdata_half;

  assign is_mem      = is_load | is_store;
  assign accept      = (state_q == IDLE) && valid_in && !halt;
  assign timeout_hit = (cnt_q == CNT_W'(DMEM_TIMEOUT - 1));
  assign stall_out   = (state_q != IDLE) || (valid_in && is_mem && (state_q == IDLE) && !halt);

  // Loads take priority if both class bits are set.
  assign legal_f3   = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (funct3 inside {3'b000, 3'b001, 3'b010});
  assign misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'hF;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rdata_bytes[gi] = dmem.dmem_rdata[8*gi +: 8];
  end
  assign rdata_half = addr_lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    load_data_d = dmem.dmem_rdata;
    case (funct3_q)
      3'b000:  load_data_d = {{24{rdata_bytes[addr_lo_q][7]}}, rdata_bytes[addr_lo_q]};
      3'b001:  load_data_d = {{16{rdata_half[15]}}, rdata_half};
      3'b100:  load_data_d = {24'd0, rdata_bytes[addr_lo_q]};
      3'b101:  load_data_d = {16'd0, rdata_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_be_q      <= '0;
      dmem_wdata_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      mem_exc_q      <= 1'b0;
      mem_err_q      <= 1'b0;
      cnt_q          <= '0;
      funct3_q       <= '0;
      addr_lo_q      <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      is_load_q      <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      mem_exc_q  <= 1'b0;
      mem_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= alu_result;
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= reg_write_in;
            end else if (!legal_f3 || misaligned) begin
              wb_valid_q     <= 1'b1;
              mem_exc_q      <= 1'b1;
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= 1'b0;
            end else begin
              state_q      <= REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= !is_load;
              dmem_addr_q  <= {alu_result[31:2], 2'b00};
              dmem_be_q    <= is_load ? 4'hF : be_d;
              dmem_wdata_q <= wdata_d;
              cnt_q        <= '0;
              funct3_q     <= funct3;
              addr_lo_q    <= alu_result[1:0];
              rd_q         <= rd_in;
              reg_write_q  <= reg_write_in;
              is_load_q    <= is_load;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // A grant that also completes the op wins over the timeout in the same cycle.
          if (dmem.dmem_gnt && (!is_load_q || dmem.dmem_rvalid)) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= is_load_q ? reg_write_q : 1'b0;
            if (is_load_q) wb_data_q <= load_data_d;
          end else if (timeout_hit) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            wb_valid_q     <= 1'b1;
            mem_err_q      <= 1'b1;
            wb_reg_write_q <= 1'b0;
          end else if (dmem.dmem_gnt) begin
            state_q    <= WAIT;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.dmem_rvalid) begin
            state_q        <= IDLE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= load_data_d;
            wb_rd_q        <= rd_q;
            wb_reg_write_q <= reg_write_q;
          end else if (timeout_hit) begin
            state_q        <= IDLE;
            wb_valid_q     <= 1'b1;
            mem_err_q      <= 1'b1;
            wb_reg_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_be    = dmem_be_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign mem_exc         = mem_exc_q;
  assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table driven through a small memory
// responder, plus hand sequences for reset, halt and late-response corners.
module tb_load_store_unit;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        stall_out;
  logic        mem_exc;
  logic        mem_err;

  load_store_unit_if dmem_bus();

  load_store_unit #(.DMEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .valid_in     (valid_in),
    .is_load      (is_load),
    .is_store     (is_store),
    .funct3       (funct3),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .dmem         (dmem_bus),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .stall_out    (stall_out),
    .mem_exc      (mem_exc),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    bit          rw;
    int          gnt_dly;
    bit          zero_wait;
    bit          no_rvalid;
    logic [31:0] rdata;
    bit          x_req;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    bit          x_we;
    bit          chk_data;
    logic [31:0] x_data;
    bit          x_rw;
    bit          x_exc;
    bit          x_err;
    int          x_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, req_cyc, lat;
    bit got_req, granted, rv_sent, stable, g;
    logic [31:0] c_addr, c_wdata, c_data;
    logic [3:0]  c_be;
    logic        c_we, c_rw, c_exc, c_err;
    logic [4:0]  c_rd;
    cyc = 0; req_cyc = 0; lat = -1;
    got_req = 0; granted = 0; rv_sent = 0; stable = 1;
    c_addr = '0; c_wdata = '0; c_data = '0; c_be = '0; c_we = 0;
    c_rw = 0; c_exc = 0; c_err = 0; c_rd = '0;

    @(negedge clk);
    valid_in = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
    alu_result = v.addr; store_data = v.sdata; rd_in = v.rd; reg_write_in = v.rw;
    #1 chk({v.name, ".stall_accept"}, stall_out, v.ld | v.st);
    @(posedge clk); #1;
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    #1;
    while (cyc <= TO + 20) begin
      if (wb_valid) begin
        lat = cyc; c_data = wb_data; c_rd = wb_rd; c_rw = wb_reg_write;
        c_exc = mem_exc; c_err = mem_err;
        break;
      end
      if (dmem_bus.dmem_req) begin
        if (!got_req) begin
          c_addr = dmem_bus.dmem_addr; c_be = dmem_bus.dmem_be;
          c_wdata = dmem_bus.dmem_wdata; c_we = dmem_bus.dmem_we;
          got_req = 1;
        end else if (dmem_bus.dmem_addr !== c_addr || dmem_bus.dmem_be !== c_be ||
                     dmem_bus.dmem_wdata !== c_wdata || dmem_bus.dmem_we !== c_we) begin
          stable = 0;
        end
        dmem_bus.dmem_gnt = (req_cyc >= v.gnt_dly);
        req_cyc++;
      end else begin
        dmem_bus.dmem_gnt = 1'b0;
      end
      if (v.ld && !v.no_rvalid && !rv_sent &&
          ((dmem_bus.dmem_gnt && v.zero_wait) || (granted && !v.zero_wait))) begin
        dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = v.rdata; rv_sent = 1;
      end else begin
        dmem_bus.dmem_rvalid = 1'b0;
      end
      g = dmem_bus.dmem_gnt;
      @(posedge clk); #2;
      granted = granted | g;
      cyc++;
    end
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;

    $display("vec %0d %s: lat=%0d req=%0b addr=%h be=%h wdata=%h we=%0b wb_data=%h rw=%0b exc=%0b err=%0b",
             idx, v.name, lat, got_req, c_addr, c_be, c_wdata, c_we, c_data, c_rw, c_exc, c_err);
    chk({v.name, ".latency"}, lat, v.x_lat);
    chk({v.name, ".dmem_req"}, got_req, v.x_req);
    if (v.x_req) begin
      chk({v.name, ".dmem_addr"}, c_addr, v.x_addr);
      chk({v.name, ".dmem_be"}, c_be, v.x_be);
      chk({v.name, ".dmem_we"}, c_we, v.x_we);
      chk({v.name, ".req_stable"}, stable, 1);
      if (v.st) chk({v.name, ".dmem_wdata"}, c_wdata, v.x_wdata);
    end
    chk({v.name, ".wb_reg_write"}, c_rw, v.x_rw);
    chk({v.name, ".mem_exc"}, c_exc, v.x_exc);
    chk({v.name, ".mem_err"}, c_err, v.x_err);
    if (v.chk_data) begin
      chk({v.name, ".wb_data"}, c_data, v.x_data);
      chk({v.name, ".wb_rd"}, c_rd, v.rd);
    end
    @(posedge clk); #2;
    chk({v.name, ".pulse_end"}, {wb_valid, mem_exc, mem_err, dmem_bus.dmem_req, stall_out}, 5'b0);
  endtask

  initial begin
    //           name      ld st f3      addr           sdata          rd rw gd  zw nr rdata          xr x_addr      x_be     x_wdata        we cd x_data         xrw xe xe lat
    vecs[0]  = '{"alu",    0, 0, 3'b000, 32'h0000_1234, 32'h0,         5, 1, 0,  0, 0, 32'h0,         0, 32'h0,      4'h0,    32'h0,         0, 1, 32'h0000_1234, 1, 0, 0, 0};
    vecs[1]  = '{"lb",     1, 0, 3'b000, 32'h0000_0103, 32'h0,         7, 1, 2,  0, 0, 32'h80FF_0000, 1, 32'h100,    4'hF,    32'h0,         0, 1, 32'hFFFF_FF80, 1, 0, 0, 4};
    vecs[2]  = '{"sh",     0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 8, 1, 0,  0, 0, 32'h0,         1, 32'h200,    4'b1100, 32'hBEEF_BEEF, 1, 0, 32'h0,         0, 0, 0, 1};
    vecs[3]  = '{"lw_mis", 1, 0, 3'b010, 32'h0000_0006, 32'h0,         4, 1, 0,  0, 0, 32'h0,         0, 32'h0,      4'h0,    32'h0,         0, 0, 32'h0,         0, 1, 0, 0};
    vecs[4]  = '{"lbu_zw", 1, 0, 3'b100, 32'h0000_0401, 32'h0,        10, 1, 0,  1, 0, 32'h1234_A5C3, 1, 32'h400,    4'hF,    32'h0,         0, 1, 32'h0000_00A5, 1, 0, 0, 1};
    vecs[5]  = '{"lh",     1, 0, 3'b001, 32'h0000_0502, 32'h0,        11, 1, 1,  0, 0, 32'h8001_7FFF, 1, 32'h500,    4'hF,    32'h0,         0, 1, 32'hFFFF_8001, 1, 0, 0, 3};
    vecs[6]  = '{"lhu",    1, 0, 3'b101, 32'h0000_0500, 32'h0,        13, 1, 0,  0, 0, 32'h8001_FFFE, 1, 32'h500,    4'hF,    32'h0,         0, 1, 32'h0000_FFFE, 1, 0, 0, 2};
    vecs[7]  = '{"lw_zw",  1, 0, 3'b010, 32'h0000_0600, 32'h0,        14, 1, 0,  1, 0, 32'hDEAD_BEEF, 1, 32'h600,    4'hF,    32'h0,         0, 1, 32'hDEAD_BEEF, 1, 0, 0, 1};
    vecs[8]  = '{"sb",     0, 1, 3'b000, 32'h0000_0701, 32'h1234_5678, 2, 0, 3,  0, 0, 32'h0,         1, 32'h700,    4'b0010, 32'h7878_7878, 1, 0, 32'h0,         0, 0, 0, 4};
    vecs[9]  = '{"sw",     0, 1, 3'b010, 32'h0000_0800, 32'hCAFE_F00D, 3, 1, 0,  0, 0, 32'h0,         1, 32'h800,    4'hF,    32'hCAFE_F00D, 1, 0, 32'h0,         0, 0, 0, 1};
    vecs[10] = '{"sh_mis", 0, 1, 3'b001, 32'h0000_0203, 32'h1,         6, 1, 0,  0, 0, 32'h0,         0, 32'h0,      4'h0,    32'h0,         0, 0, 32'h0,         0, 1, 0, 0};
    vecs[11] = '{"ld_ill", 1, 0, 3'b011, 32'h0000_0000, 32'h0,         6, 1, 0,  0, 0, 32'h0,         0, 32'h0,      4'h0,    32'h0,         0, 0, 32'h0,         0, 1, 0, 0};
    vecs[12] = '{"st_ill", 0, 1, 3'b100, 32'h0000_0000, 32'h0,         6, 1, 0,  0, 0, 32'h0,         0, 32'h0,      4'h0,    32'h0,         0, 0, 32'h0,         0, 1, 0, 0};
    vecs[13] = '{"lb_pos", 1, 0, 3'b000, 32'h0000_0900, 32'h0,        12, 0, 0,  0, 0, 32'h0000_007F, 1, 32'h900,    4'hF,    32'h0,         0, 1, 32'h0000_007F, 0, 0, 0, 2};
    vecs[14] = '{"lw_to",  1, 0, 3'b010, 32'h0000_0A00, 32'h0,        15, 1, 0,  0, 1, 32'h0,         1, 32'hA00,    4'hF,    32'h0,         0, 0, 32'h0,         0, 0, 1, TO};
    vecs[15] = '{"sw_to",  0, 1, 3'b010, 32'h0000_0B00, 32'h0BAD_CAFE, 16, 1, 100000, 0, 0, 32'h0, 1, 32'hB00,    4'hF,    32'h0BAD_CAFE, 1, 0, 32'h0,         0, 0, 1, TO};

    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dmem_req", dmem_bus.dmem_req, 0);
    chk("rst.dmem_we", dmem_bus.dmem_we, 0);
    chk("rst.dmem_be", dmem_bus.dmem_be, 0);
    chk("rst.dmem_addr", dmem_bus.dmem_addr, 0);
    chk("rst.dmem_wdata", dmem_bus.dmem_wdata, 0);
    chk("rst.wb", {wb_valid, wb_reg_write, mem_exc, mem_err, stall_out}, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wb_rd", wb_rd, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Late rvalid while idle must not produce a writeback
    @(negedge clk);
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    chk("late_rvalid.wb_valid", {wb_valid, mem_err, mem_exc}, 0);
    @(posedge clk); #1;
    chk("late_rvalid.wb_valid2", wb_valid, 0);
    $display("seq late_rvalid done");

    // Halt raised during WAIT: in-flight load still completes, new ops blocked
    @(negedge clk);
    valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0C00;
    rd_in = 5'd9; reg_write_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; is_load = 1'b0;
    dmem_bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_gnt = 1'b0;
    halt = 1'b1;
    chk("halt.stall_wait", stall_out, 1);
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    chk("halt.wb_valid", wb_valid, 1);
    chk("halt.wb_data", wb_data, 32'h1122_3344);
    chk("halt.wb_rd", wb_rd, 9);
    chk("halt.wb_reg_write", wb_reg_write, 1);
    valid_in = 1'b1; is_load = 1'b0; is_store = 1'b0; alu_result = 32'h0000_0055;
    rd_in = 5'd3; reg_write_in = 1'b1;
    #1 chk("halt.stall_blocked", stall_out, 0);
    @(posedge clk); #1;
    chk("halt.blocked1", wb_valid, 0);
    @(posedge clk); #1;
    chk("halt.blocked2", wb_valid, 0);
    halt = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("halt.release_wb", wb_valid, 1);
    chk("halt.release_data", wb_data, 32'h0000_0055);
    $display("seq halt_wait done");

    // Reset mid-transaction drops the request at once and loses the op
    @(negedge clk);
    valid_in = 1'b1; is_store = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0D00;
    store_data = 32'h0000_0001;
    @(posedge clk); #1;
    valid_in = 1'b0; is_store = 1'b0;
    chk("arst.req_before", dmem_bus.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("arst.req_dropped", {dmem_bus.dmem_req, dmem_bus.dmem_we, stall_out}, 0);
    @(negedge clk); rst_n = 1'b1;
    dmem_bus.dmem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("arst.no_wb", {wb_valid, dmem_bus.dmem_req}, 0);
    end
    dmem_bus.dmem_gnt = 1'b0;
    $display("seq async_reset done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
